// File: rtl/irq_arbiter.sv
// irq_arbiter: four-source priority interrupt arbiter with a pending register,
// a mask, an in-service register and nested preemption. All state updates
// happen on the falling edge of T3. CLR is asynchronous and overrides
// everything else.
//
// INTR/INTA handshake: INTR is the request (valid) and INTA the acknowledge
// (ready). While INTR=1, VEC is stable and names the requested source. A
// transfer completes on a falling T3 edge where INTR=1 and INTA=1. INTR may
// also drop without a transfer (withdrawal) when EI falls or the source stops
// being eligible. INTA seen while INTR=0 is ignored. At least one cycle with
// INTR=0 separates two requests.
`timescale 1ns/1ps

module irq_arbiter (
    input  logic       T3,
    input  logic       CLR,
    input  logic [3:0] IRQ,
    input  logic       MASK_WE,
    input  logic [3:0] MASK_IN,
    input  logic       EI,
    input  logic       INTA,
    input  logic       EOI,
    output logic       INTR,
    output logic [1:0] VEC,
    output logic [3:0] PEND,
    output logic [3:0] ISR,
    output logic       BUSY,
    output logic       STATE
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] irq_q;
    logic [3:0] mask;
    logic [3:0] rise;
    logic [3:0] elig;
    logic [1:0] elig_idx;
    logic [2:0] lim;
    logic [3:0] ack_set;
    logic [3:0] eoi_clr;

    // Debug view of the FSM state.
    assign STATE = state;

    // Any in-service source marks the arbiter busy.
    assign BUSY = |ISR;

    // Rising edges of the request lines against last edge's sample.
    assign rise = IRQ & ~irq_q;

    // An acknowledge only takes effect while a request is outstanding.
    assign ack_set = (state == REQ && INTA) ? (4'b0001 << VEC) : 4'b0000;

    // EOI retires the highest-priority (lowest-index) in-service source.
    assign eoi_clr = EOI ? (ISR & (~ISR + 4'd1)) : 4'b0000;

    // Priority limit: index of the lowest in-service bit, 4 when nothing is in service.
    always_comb begin
        lim = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (ISR[i]) lim = 3'(i);
        end
    end

    // Eligible sources: pending, unmasked and strictly above the in-service level.
    always_comb begin
        elig     = 4'b0000;
        elig_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            elig[i] = PEND[i] & ~mask[i] & (3'(i) < lim);
            if (elig[i]) elig_idx = 2'(i);
        end
    end

    // Request history, mask, pending and in-service registers.
    always_ff @(negedge T3 or posedge CLR) begin
        if (CLR) begin
            irq_q <= 4'b0000;
            mask  <= 4'b0000;
            PEND  <= 4'b0000;
            ISR   <= 4'b0000;
        end else begin
            irq_q <= IRQ;
            if (MASK_WE) mask <= MASK_IN;
            // A new rising edge wins over the acknowledge clear of the same bit.
            PEND  <= (PEND & ~ack_set) | rise;
            // EOI works on the pre-edge ISR; the acknowledge set is applied after it.
            ISR   <= (ISR & ~eoi_clr) | ack_set;
        end
    end

    // Request FSM with registered INTR and VEC.
    always_ff @(negedge T3 or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            INTR  <= 1'b0;
            VEC   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (EI && (elig != 4'b0000)) begin
                        state <= REQ;
                        INTR  <= 1'b1;
                        VEC   <= elig_idx;
                    end else begin
                        INTR  <= 1'b0;
                    end
                end
                REQ: begin
                    if (INTA) begin
                        state <= IDLE;
                        INTR  <= 1'b0;
                    end else if (!EI || !elig[VEC]) begin
                        // Withdraw; the pending bit is kept for a later request.
                        state <= IDLE;
                        INTR  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    INTR  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus randomized traffic for irq_arbiter,
// checked against a behavioural model through an expected-snapshot queue.
`timescale 1ns/1ps

module tb_irq_arbiter;

    // ---------------- clock / reset ----------------
    logic       T3;
    logic       CLR;
    logic [3:0] IRQ;
    logic       MASK_WE;
    logic [3:0] MASK_IN;
    logic       EI;
    logic       INTA;
    logic       EOI;
    logic       INTR;
    logic [1:0] VEC;
    logic [3:0] PEND;
    logic [3:0] ISR;
    logic       BUSY;
    logic       state_dbg;

    initial T3 = 1'b1;
    always #5 T3 = ~T3;

    irq_arbiter dut (
        .T3      (T3),
        .CLR     (CLR),
        .IRQ     (IRQ),
        .MASK_WE (MASK_WE),
        .MASK_IN (MASK_IN),
        .EI      (EI),
        .INTA    (INTA),
        .EOI     (EOI),
        .INTR    (INTR),
        .VEC     (VEC),
        .PEND    (PEND),
        .ISR     (ISR),
        .BUSY    (BUSY),
        .STATE   (state_dbg)
    );

    int compared   = 0;
    int mismatched = 0;

    // expected snapshot: {INTR, VEC[1:0], PEND[3:0], ISR[3:0], BUSY}
    logic [11:0] exp_q[$];

    // ---------------- reference model ----------------
    bit m_pend[4];
    bit m_isr[4];
    bit m_mask[4];
    bit m_irq_q[4];
    bit m_req;
    bit m_intr;
    int m_vec;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i]  = 0;
            m_isr[i]   = 0;
            m_mask[i]  = 0;
            m_irq_q[i] = 0;
        end
        m_req  = 0;
        m_intr = 0;
        m_vec  = 0;
    endtask

    task automatic model_step(input logic [3:0] irq, input logic ei, input logic inta,
                              input logic eoi, input logic mwe, input logic [3:0] min,
                              input logic clr);
        int lim;
        int pick;
        bit elig[4];
        bit n_pend[4];
        bit n_isr[4];
        if (clr) begin
            model_reset();
            return;
        end
        lim = 4;
        for (int i = 3; i >= 0; i--) if (m_isr[i]) lim = i;
        pick = -1;
        for (int i = 3; i >= 0; i--) begin
            elig[i] = m_pend[i] && !m_mask[i] && (i < lim);
            if (elig[i]) pick = i;
        end
        n_pend = m_pend;
        n_isr  = m_isr;
        if (eoi && lim < 4) n_isr[lim] = 0;
        if (!m_req) begin
            if (ei && pick >= 0) begin
                m_req  = 1;
                m_intr = 1;
                m_vec  = pick;
            end else begin
                m_intr = 0;
            end
        end else if (inta) begin
            n_pend[m_vec] = 0;
            n_isr[m_vec]  = 1;
            m_req  = 0;
            m_intr = 0;
        end else if (!ei || !elig[m_vec]) begin
            m_req  = 0;
            m_intr = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (irq[i] && !m_irq_q[i]) n_pend[i] = 1;
            m_irq_q[i] = irq[i];
            if (mwe) m_mask[i] = min[i];
        end
        m_pend = n_pend;
        m_isr  = n_isr;
    endtask

    function automatic logic [11:0] model_snapshot();
        logic [3:0] p;
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            p[i] = m_pend[i];
            s[i] = m_isr[i];
        end
        return {m_intr, 2'(m_vec), p, s, |s};
    endfunction

    // ---------------- driver tasks ----------------
    // One T3 period: inputs change on the rising edge, the model steps at the
    // falling edge, and the task returns 2ns after the falling edge.
    task automatic cyc(input logic [3:0] irq, input logic ei, input logic inta,
                       input logic eoi, input logic mwe = 1'b0, input logic [3:0] min = 4'b0000);
        @(posedge T3);
        IRQ     = irq;
        EI      = ei;
        INTA    = inta;
        EOI     = eoi;
        MASK_WE = mwe;
        MASK_IN = min;
        @(negedge T3);
        model_step(irq, ei, inta, eoi, mwe, min, CLR);
        exp_q.push_back(model_snapshot());
        #2;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [11:0] exp;
        logic [11:0] got;
        forever begin
            @(negedge T3);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {INTR, VEC, PEND, ISR, BUSY};
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL edge_snapshot at %0t: got INTR=%b VEC=%0d PEND=%b ISR=%b BUSY=%b want INTR=%b VEC=%0d PEND=%b ISR=%b BUSY=%b",
                             $time, got[11], got[10:9], got[8:5], got[4:1], got[0],
                             exp[11], exp[10:9], exp[8:5], exp[4:1], exp[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] irq_r;
        CLR = 1'b1; IRQ = 4'b0; MASK_WE = 1'b0; MASK_IN = 4'b0;
        EI = 1'b0; INTA = 1'b0; EOI = 1'b0;
        model_reset();
        cyc(4'b0000, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0);
        chk("reset_pend", PEND, 4'b0000);
        chk("reset_intr", {3'b0, INTR}, 4'd0);
        CLR = 1'b0;
        cyc(4'b0000, 1, 0, 0);

        // single pulse on source 2
        cyc(4'b0100, 1, 0, 0);
        chk("s1_pend_edge_n", PEND, 4'b0100);
        chk("s1_intr_edge_n", {3'b0, INTR}, 4'd0);
        cyc(4'b0000, 1, 0, 0);
        chk("s1_intr", {3'b0, INTR}, 4'd1);
        chk("s1_vec", {2'b0, VEC}, 4'd2);
        cyc(4'b0000, 1, 1, 0);
        chk("s1_pend_ack", PEND, 4'b0000);
        chk("s1_isr_ack", ISR, 4'b0100);
        chk("s1_intr_ack", {3'b0, INTR}, 4'd0);
        cyc(4'b0000, 1, 0, 1);
        chk("s1_isr_eoi", ISR, 4'b0000);

        // simultaneous sources 1 and 3
        cyc(4'b1010, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);
        chk("s2_vec", {2'b0, VEC}, 4'd1);
        cyc(4'b0000, 1, 1, 0);
        chk("s2_pend", PEND, 4'b1000);
        chk("s2_isr", ISR, 4'b0010);
        cyc(4'b0000, 1, 0, 0);
        chk("s2_withheld", {3'b0, INTR}, 4'd0);
        cyc(4'b0000, 1, 0, 1);
        chk("s2_isr_eoi", ISR, 4'b0000);
        cyc(4'b0000, 1, 0, 0);
        chk("s2_intr3", {3'b0, INTR}, 4'd1);
        chk("s2_vec3", {2'b0, VEC}, 4'd3);
        cyc(4'b0000, 1, 1, 0);
        cyc(4'b0000, 1, 0, 1);

        // preemption of source 2 by source 0
        cyc(4'b0100, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);
        cyc(4'b0000, 1, 1, 0);
        chk("s3_isr2", ISR, 4'b0100);
        cyc(4'b0001, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);
        chk("s3_intr", {3'b0, INTR}, 4'd1);
        chk("s3_vec", {2'b0, VEC}, 4'd0);
        cyc(4'b0000, 1, 1, 0);
        chk("s3_isr_nested", ISR, 4'b0101);
        cyc(4'b0000, 1, 0, 1);
        chk("s3_isr_eoi", ISR, 4'b0100);
        cyc(4'b0000, 1, 0, 1);

        // withdrawal by EI and re-request
        cyc(4'b0100, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);
        chk("s4_vec", {2'b0, VEC}, 4'd2);
        cyc(4'b0000, 0, 0, 0);
        chk("s4_withdraw", {3'b0, INTR}, 4'd0);
        chk("s4_pend_kept", PEND, 4'b0100);
        cyc(4'b0000, 1, 0, 0);
        chk("s4_rereq", {3'b0, INTR}, 4'd1);
        chk("s4_rereq_vec", {2'b0, VEC}, 4'd2);
        cyc(4'b0000, 1, 1, 0);
        cyc(4'b0000, 1, 0, 1);

        // mask
        cyc(4'b0000, 1, 0, 0, 1'b1, 4'b0001);
        cyc(4'b0001, 1, 0, 0);
        chk("s5_pend", PEND, 4'b0001);
        cyc(4'b0000, 1, 0, 0);
        chk("s5_masked", {3'b0, INTR}, 4'd0);
        cyc(4'b0000, 1, 0, 0, 1'b1, 4'b0000);
        chk("s5_mask_delay", {3'b0, INTR}, 4'd0);
        cyc(4'b0000, 1, 0, 0);
        chk("s5_unmasked", {3'b0, INTR}, 4'd1);
        chk("s5_vec", {2'b0, VEC}, 4'd0);
        cyc(4'b0000, 1, 1, 0);
        cyc(4'b0000, 1, 0, 1);

        // asynchronous clear in the middle of a request
        cyc(4'b1000, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);
        cyc(4'b0000, 1, 1, 0);
        cyc(4'b0110, 1, 0, 0);
        chk("s6_pend", PEND, 4'b0110);
        chk("s6_isr", ISR, 4'b1000);
        cyc(4'b0010, 1, 0, 0);
        chk("s6_intr_before", {3'b0, INTR}, 4'd1);
        #1;
        CLR = 1'b1;
        #1;
        chk("s6_async_intr", {3'b0, INTR}, 4'd0);
        chk("s6_async_vec", {2'b0, VEC}, 4'd0);
        chk("s6_async_pend", PEND, 4'b0000);
        chk("s6_async_isr", ISR, 4'b0000);
        chk("s6_async_busy", {3'b0, BUSY}, 4'd0);
        model_reset();
        cyc(4'b0010, 1, 0, 0);
        CLR = 1'b0;
        cyc(4'b0010, 1, 0, 0);
        chk("s6_release_pend", PEND, 4'b0010);
        cyc(4'b0010, 1, 0, 0);
        cyc(4'b0010, 1, 1, 0);
        cyc(4'b0000, 1, 0, 1);

        // randomized traffic
        irq_r = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            logic ei_r, inta_r, eoi_r, mwe_r;
            logic [3:0] min_r;
            irq_r  = irq_r ^ 4'($urandom & $urandom);
            ei_r   = ($urandom_range(0, 7) != 0);
            inta_r = m_intr ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            eoi_r  = ($urandom_range(0, 5) == 0);
            mwe_r  = ($urandom_range(0, 15) == 0);
            min_r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            CLR    = ($urandom_range(0, 299) == 0);
            cyc(irq_r, ei_r, inta_r, eoi_r, mwe_r, min_r);
        end
        CLR = 1'b0;
        cyc(4'b0000, 1, 0, 0);
        cyc(4'b0000, 1, 0, 0);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
